// File: rtl/pipe_reg.sv
// pipe_reg: elastic valid/ready pipeline of DEPTH stages with flush and occupancy count.
// Define PIPE_REG_STATS_EN to add the saturating stall_cnt output.
module pipe_reg #(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
`ifdef PIPE_REG_STATS_EN
  output logic [15:0]                stall_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg: DEPTH must be >= 1");
  end
  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] w_rdy;
  logic             w_in_xfer;
  logic             w_out_xfer;
  // A stage can load unless it and every stage after it are full and the output is stalled.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
    assign w_rdy[g] = ~(&r_v[DEPTH-1:g]) | out_ready;
  end
  assign in_ready   = w_rdy[0] & ~flush;
  assign out_valid  = r_v[DEPTH-1] & ~flush;
  assign out_data   = r_d[DEPTH-1];
  assign count      = r_count;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) r_d[k] <= RESET_VAL;
    end else if (flush) begin
      r_v <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_v[0] <= in_valid;
        r_d[0] <= in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (w_rdy[k]) begin
          r_v[k] <= r_v[k-1];
          r_d[k] <= r_d[k-1];
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_count <= '0;
    else r_count <= flush ? '0 : r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
  end
`ifdef PIPE_REG_STATS_EN
  logic [15:0] r_stall;
  assign stall_cnt = r_stall;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_stall <= '0;
    else if (out_valid && !out_ready && !(&r_stall)) r_stall <= r_stall + 16'd1;
  end
`endif
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed-vector bench for pipe_reg with DEPTH=2, RESET_VAL=32'hDEADBEEF.
module tb_pipe_reg;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush;
  logic [1:0]  count;
`ifdef PIPE_REG_STATS_EN
  logic [15:0] stall_cnt;
`endif
  int tests = 0;
  int fails = 0;

  pipe_reg #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush),
`ifdef PIPE_REG_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'hDEAD_BEEF);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_REG_STATS_EN
    check("rst_stall", 32'(stall_cnt), 32'd0);
`endif
    reset = 1'b1;
    tick;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_out_data", out_data, 32'hDEAD_BEEF);
    check("idle_count", 32'(count), 32'd0);

    // stream 1,2,3 with out_ready high
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
    tick;
    check("s_cnt1", 32'(count), 32'd1);
    check("s_ov1", 32'(out_valid), 32'd0);
    in_data = 32'h2;
    tick;
    check("s_out1", out_data, 32'h1);
    check("s_ov2", 32'(out_valid), 32'd1);
    check("s_cnt2", 32'(count), 32'd2);
    in_data = 32'h3;
    tick;
    check("s_out2", out_data, 32'h2);
    check("s_cnt3", 32'(count), 32'd2);
    in_valid = 1'b0;
    tick;
    check("s_out3", out_data, 32'h3);
    check("s_cnt4", 32'(count), 32'd1);
    tick;
    check("s_empty_ov", 32'(out_valid), 32'd0);
    check("s_empty_hold", out_data, 32'h3);
    check("s_empty_cnt", 32'(count), 32'd0);

    // backpressure: fill with A,B while out_ready low
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick;
    in_data = 32'hB;
    tick;
    in_data = 32'hC;
    check("bp_cnt", 32'(count), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out", out_data, 32'hA);
    tick;
    check("bp_hold_cnt", 32'(count), 32'd2);
    check("bp_hold_out", out_data, 32'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_ov", 32'(out_valid), 32'd1);
    tick;
    check("bp_out_b", out_data, 32'hB);
    check("bp_cnt_b", 32'(count), 32'd1);
    tick;
    check("bp_drained_ov", 32'(out_valid), 32'd0);
    check("bp_drained_cnt", 32'(count), 32'd0);

    // flush a full pipe while offering 0x55
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    tick;
    in_data = 32'h22;
    tick;
    check("fl_full_cnt", 32'(count), 32'd2);
    flush = 1'b1; in_data = 32'h55;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    check("fl_ov_forced", 32'(out_valid), 32'd0);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    check("fl_cnt", 32'(count), 32'd0);
    check("fl_ov", 32'(out_valid), 32'd0);
    check("fl_data_kept", out_data, 32'h11);
    out_ready = 1'b1;
    tick;
    check("fl_no55_a", 32'(out_valid), 32'd0);
    tick;
    check("fl_no55_b", 32'(out_valid), 32'd0);

    // full then continuous in/out, then async reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h31;
    tick;
    in_data = 32'h32;
    tick;
    out_ready = 1'b1; in_data = 32'h33;
    #1;
    check("cs_in_ready", 32'(in_ready), 32'd1);
    check("cs_out0", out_data, 32'h31);
    tick;
    check("cs_out1", out_data, 32'h32);
    check("cs_cnt1", 32'(count), 32'd2);
    in_data = 32'h34;
    tick;
    check("cs_out2", out_data, 32'h33);
    check("cs_cnt2", 32'(count), 32'd2);
    #1;
    reset = 1'b0;
    #1;
    check("ar_ov", 32'(out_valid), 32'd0);
    check("ar_data", out_data, 32'hDEAD_BEEF);
    check("ar_cnt", 32'(count), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    #4;
    reset = 1'b1;
    tick;

`ifdef PIPE_REG_STATS_EN
    in_valid = 1'b1; in_data = 32'h41;
    tick;
    in_valid = 1'b0;
    tick;
    check("st_start", 32'(stall_cnt), 32'd0);
    for (int n = 0; n < 5; n++) tick;
    check("st_five", 32'(stall_cnt), 32'd5);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("st_after_flush", 32'(stall_cnt), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check("st_reset", 32'(stall_cnt), 32'd0);
    reset = 1'b1;
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
